// File: rtl/sm83_bus_pkg.sv
// sm83_bus_pkg: shared bus types, register addresses and interrupt bit indices
package sm83_bus_pkg;
  typedef logic [7:0] word_t;
  typedef logic [15:0] adr_t;
  localparam adr_t IF_ADR = 16'hFF0F;
  localparam adr_t IE_ADR = 16'hFFFF;
  localparam int VBLANK = 0;
  localparam int STAT = 1;
  localparam int TIMER = 2;
  localparam int SERIAL = 3;
  localparam int JOYPAD = 4;
endpackage

// File: rtl/sm83_irq_edge.sv
// sm83_irq_edge: rising-edge detector with synchronous active-low reset
module sm83_irq_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] d_q, d_d;
  always_comb d_d = d;
  always_ff @(posedge clk)
    if (!nreset) d_q <= '0;
    else d_q <= d_d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/sm83_irq_ctrl.sv
// sm83_irq_ctrl: IF/IE interrupt controller and bus responder for the sm83 core
module sm83_irq_ctrl
  import sm83_bus_pkg::*;
#(
  parameter int   NUM_SRC = 5,
  parameter adr_t IF_ADR  = sm83_bus_pkg::IF_ADR,
  parameter adr_t IE_ADR  = sm83_bus_pkg::IE_ADR
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [15:0]        adr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               rdata_oe,
  input  logic               p_rd,
  input  logic               p_wr,
  input  logic [NUM_SRC-1:0] src,
  output logic [7:0]         irq,
  input  logic [7:0]         iack
);
  logic [NUM_SRC-1:0] if_q, if_d, src_rise;
  word_t              ie_q, ie_d, if_rd;
  logic               wr_stb, hit_if, hit_ie, wr_if, wr_ie;
  logic               unused_iack;
  sm83_irq_edge #(.W(NUM_SRC)) u_src_edge (
    .clk(clk), .nreset(nreset), .d(src), .rise(src_rise)
  );
  sm83_irq_edge #(.W(1)) u_wr_edge (
    .clk(clk), .nreset(nreset), .d(p_wr), .rise(wr_stb)
  );
  assign unused_iack = ^(iack >> NUM_SRC);
  // a new edge outranks both the acknowledge and a write-clear
  always_comb begin
    hit_if = adr == IF_ADR;
    hit_ie = adr == IE_ADR;
    wr_if = wr_stb & hit_if;
    wr_ie = wr_stb & hit_ie;
    if_d = ((wr_if ? wdata[NUM_SRC-1:0] : if_q) & ~iack[NUM_SRC-1:0]) | src_rise;
    ie_d = wr_ie ? wdata : ie_q;
    if_rd = '1;
    if_rd[NUM_SRC-1:0] = if_q;
    rdata = hit_if ? if_rd : hit_ie ? ie_q : 8'hFF;
    rdata_oe = p_rd & (hit_if | hit_ie);
    irq = 8'(if_q & ie_q[NUM_SRC-1:0]);
  end
  always_ff @(posedge clk)
    if (!nreset) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
    end
endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb_sm83_irq_ctrl: directed stimulus with a queue-based scoreboard and negedge monitor
module tb_sm83_irq_ctrl;
  logic        clk = 0, nreset = 0, p_rd = 0, p_wr = 0;
  logic [15:0] adr = 0;
  logic [7:0]  wdata = 0, rdata, irq, iack = 0;
  logic        rdata_oe;
  logic [4:0]  src = 0;
  int          cyc = 0, total = 0, bad = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] v;
    string      name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] mon_act;

  sm83_irq_ctrl dut (
    .clk(clk), .nreset(nreset), .adr(adr), .wdata(wdata), .rdata(rdata),
    .rdata_oe(rdata_oe), .p_rd(p_rd), .p_wr(p_wr), .src(src), .irq(irq), .iack(iack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    assert (!(p_rd && p_wr));
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      mon_act = mon_e.sel == 0 ? irq : mon_e.sel == 1 ? rdata : {7'b0, rdata_oe};
      total++;
      if (mon_act !== mon_e.v) begin
        bad++;
        $display("FAIL %s: got %h want %h (cycle %0d)", mon_e.name, mon_act, mon_e.v, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int sel, input logic [7:0] v, input string name);
    sb.push_back('{cyc, sel, v, name});
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    adr = a; wdata = d; p_wr = 1;
    step();
    p_wr = 0;
    step();
  endtask

  initial begin
    step();
    step();
    expect_v(0, 8'h00, "rst_irq");
    expect_v(1, 8'hFF, "rst_rdata");
    expect_v(2, 8'h00, "rst_oe");
    step();
    nreset = 1;
    wr(16'hFFFF, 8'h01);
    src = 5'b00001;
    step();
    expect_v(0, 8'h01, "vblank_irq");
    iack = 8'h01;
    step();
    iack = 8'h00;
    expect_v(0, 8'h00, "vblank_ack");
    for (int i = 0; i < 8; i++) begin
      step();
      expect_v(0, 8'h00, "level_held");
    end
    src = 0;
    wr(16'hFFFF, 8'h1F);
    src = 5'b00100;
    step();
    src = 0;
    expect_v(0, 8'h04, "timer_irq");
    adr = 16'hFF0F; p_rd = 1;
    expect_v(1, 8'hE4, "if_read");
    expect_v(2, 8'h01, "if_read_oe");
    step();
    p_rd = 0;
    wr(16'hFF0F, 8'h02);
    expect_v(0, 8'h02, "if_write_set");
    src = 5'b00010; iack = 8'h02;
    step();
    src = 0; iack = 0;
    expect_v(0, 8'h02, "edge_beats_iack");
    iack = 8'h02;
    step();
    iack = 0;
    expect_v(0, 8'h00, "iack_clears");
    src = 5'b00001;
    step();
    src = 0;
    expect_v(0, 8'h01, "pre_wclr");
    adr = 16'hFF0F; wdata = 8'h00; p_wr = 1; src = 5'b01000;
    step();
    p_wr = 0; src = 0;
    expect_v(0, 8'h08, "edge_beats_wclr");
    step();
    p_rd = 1;
    expect_v(1, 8'hE8, "if_after_wclr");
    step();
    p_rd = 0;
    adr = 16'hFF0F; wdata = 8'h03; p_wr = 1;
    step();
    expect_v(0, 8'h03, "hold_commit");
    step();
    iack = 8'h01;
    step();
    iack = 0;
    step();
    p_wr = 0;
    expect_v(0, 8'h02, "single_commit");
    step();
    p_rd = 1;
    expect_v(1, 8'hE2, "single_commit_rd");
    step();
    p_rd = 0;
    iack = 8'h1F;
    step();
    iack = 0;
    expect_v(0, 8'h00, "multi_iack");
    wr(16'hFF0F, 8'hFF);
    wr(16'hFFFF, 8'hE0);
    expect_v(0, 8'h00, "ie_upper_no_gate");
    adr = 16'hFF0F; p_rd = 1;
    expect_v(1, 8'hFF, "if_all_set_rd");
    step();
    adr = 16'hFFFF;
    expect_v(1, 8'hE0, "ie_readback");
    step();
    p_rd = 0;
    wr(16'hFFFF, 8'hFF);
    expect_v(0, 8'h1F, "all_enabled");
    adr = 16'h1234; p_rd = 1;
    expect_v(2, 8'h00, "miss_oe");
    expect_v(1, 8'hFF, "miss_rdata");
    step();
    p_rd = 0;
    adr = 16'hFFFF; wdata = 8'hAA; p_wr = 1; nreset = 0;
    step();
    expect_v(0, 8'h00, "rst_mid_irq");
    p_wr = 0; nreset = 1;
    step();
    p_rd = 1;
    expect_v(1, 8'h00, "rst_mid_ie");
    expect_v(2, 8'h01, "rst_mid_oe");
    step();
    adr = 16'hFF0F;
    expect_v(1, 8'hE0, "rst_mid_if");
    step();
    p_rd = 0;
    adr = 16'hFFFF; wdata = 8'h13; p_wr = 1;
    step();
    nreset = 0;
    step();
    nreset = 1;
    step();
    p_wr = 0;
    step();
    p_rd = 1;
    expect_v(1, 8'h13, "recommit_after_rst");
    step();
    p_rd = 0;
    src = 5'b10000;
    step();
    src = 0;
    expect_v(0, 8'h10, "joypad_after_rst");
    step();
    step();
    step();
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: got unchecked want checked", mon_e.name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm83_irq_ctrl.md
# sm83_irq_ctrl

Interrupt controller and memory-mapped bus responder on the far side of the sm83 core's external bus and irq/iack pair. It latches rising edges from peripheral request lines into the interrupt flag register IF, holds the interrupt enable register IE, and presents `IF & IE` to the core's `irq` input. It clears IF bits on the core's `iack` pulses, and answers core reads and writes at 0xFF0F (IF) and 0xFFFF (IE).

## Interface
- `NUM_SRC`, 5, number of implemented request sources; bits `[7:NUM_SRC]` of IF/IE read as constant and never request.
- `IF_ADR`, 16'hFF0F, IF register address.
- `IE_ADR`, 16'hFFFF, IE register address.
- `clk`  in  1  system clock; all state changes on posedge.
- `nreset`  in  1  reset, synchronous, active-low.
- `adr`  in  16  core address bus.
- `wdata`  in  8  core write data (core `dout`).
- `rdata`  out  8  read data to core `din`; valid while `rdata_oe`.
- `rdata_oe`  out  1  responder drives data bus (`p_rd` & address hit).
- `p_rd`  in  1  core read strobe, active-high.
- `p_wr`  in  1  core write strobe, active-high.
- `src`  in  NUM_SRC  peripheral request levels; bit 0 highest priority (VBlank).
- `irq`  out  8  to core `irq`: `{0, IF & IE}` for implemented bits.
- `iack`  in  8  from core, one-hot acknowledge.

## Operation
- Reset (`nreset`=0 at posedge): IF=0, IE=0, `src_q`=0, `p_wr_q`=0. Outputs after reset: `irq`=0, `rdata_oe`=0, `rdata`=8'hFF.
- Edge detect: `edge = src & ~src_q`; `src_q <= src` every cycle. Level-held sources request once.
- Write commit: on the posedge where `p_wr & ~p_wr_q` and `adr` hits. Exactly one commit per strobe, however long `p_wr` stays high.
- IF next value per bit `i < NUM_SRC`: `(wr_if ? wdata[i] : IF[i]) & ~iack[i] | edge[i]`.
  - Priority: a new edge beats iack and write-clear. iack beats write-set.
- IE next value: `wr_ie ? wdata : IE`. All 8 IE bits are stored and read back, but only `[NUM_SRC-1:0]` gate `irq`.
- Read: `rdata` is combinational from current state.
  - IF hit: `{3'b111, IF}` (unimplemented bits read 1).
  - IE hit: `IE`.
  - Otherwise: 8'hFF.
- `rdata_oe = p_rd & (adr==IF_ADR | adr==IE_ADR)`.
- `p_rd` and `p_wr` both high is illegal. The bench asserts against it, and RTL gives the write precedence for state.
- `iack` with more than one bit set clears all indicated bits (no error). `iack` on a bit whose IF is 0 has no effect.
- `irq` is purely combinational from IF and IE. The controller does no prioritisation; the core selects.

## Timing
- Source rise first sampled high at posedge k: IF bit set after posedge k, and `irq` high in cycle k+1 if enabled. Latency 1 cycle.
- Write at posedge k: the new IF/IE value is visible on `irq` and `rdata` in cycle k+1.
- iack sampled at posedge k: `irq` bit low in cycle k+1, unless an edge arrives at the same posedge.
- Reset mid-write: the reset wins and no commit occurs. `p_wr_q` clears, so a strobe still high after reset release commits once at the first posedge out of reset.
- No wait states. Reads complete in the same cycle as the strobe.

## Structure
- Shared package `sm83_bus_pkg`: `word_t`/`adr_t` typedefs, `IF_ADR`/`IE_ADR` constants, and IRQ bit index constants (VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4).
- One sub-module, `sm83_irq_edge`: parameterised-width rising-edge detector with synchronous active-low reset. It is instantiated for `src` (width NUM_SRC) and for `p_wr` (width 1).

## Test plan
- Reset, then `src`=5'b00001 held 10 cycles with IE=8'h01: `irq`=8'h01 from cycle 1. After `iack`=8'h01, `irq` stays 0 while `src` remains high.
- Write 8'h1F to 0xFFFF, then pulse `src[2]`: `irq`=8'h04. Read 0xFF0F: `rdata`=8'hE4, `rdata_oe`=1.
- Same-cycle edge on bit 1 and `iack`=8'h02 with IF[1]=1: IF[1] stays 1.
- Write 8'h00 to 0xFF0F coincident with an edge on bit 3: IF=8'h08 and `irq` reflects it.
- Hold `p_wr` 4 cycles on 0xFF0F with `wdata`=8'h03 while `iack`=8'h01 arrives in cycle 3: IF ends at 8'h02 (single commit).
- Read 0x1234 with `p_rd` high: `rdata_oe`=0. Reset asserted mid-strobe: IF=IE=0 after release, and `irq`=0.
